// File: rtl/rsa_byte_io.sv
// rsa_byte_io
// Byte-stream front end for a 256-bit modular exponentiator. Bytes arriving
// from a UART receiver are assembled MSB-first into the modulus N, the
// exponent d and then one message block M per exponentiation. The block
// drives the exponentiator start/ready handshake and streams the result S
// back out MSB byte first. The key is loaded once after reset and retained
// across message blocks.
//
// Optional feature: define RSA_IO_REKEY_EN to add the `rekey` input, which
// returns the block to loading N (and then d) when sampled high in LOAD_M
// before the first message byte. Without it the key changes only via reset.
//
// Ports:
//   clk       in   1         system clock, rising edge
//   reset     in   1         asynchronous active-low reset
//   rekey     in   1         (RSA_IO_REKEY_EN only) request a new key
//   rx_data   in   8         received byte
//   rx_valid  in   1         one-cycle strobe, rx_data valid
//   tx_data   out  8         byte to transmit
//   tx_valid  out  1         tx_data valid, held until accepted
//   tx_ready  in   1         transmitter accepts when tx_valid && tx_ready
//   me_M      out  KEY_BITS  message operand
//   me_N      out  KEY_BITS  modulus operand
//   me_d      out  KEY_BITS  exponent operand
//   me_start  out  1         one-cycle start pulse
//   me_ready  in   1         exponentiator idle/done
//   me_S      in   KEY_BITS  exponentiation result
//   rx_drop   out  1         pulses when an rx byte is discarded
module rsa_byte_io #(
    parameter int KEY_BITS = 256
) (
    input  logic                clk,
    input  logic                reset,
`ifdef RSA_IO_REKEY_EN
    input  logic                rekey,
`endif
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [KEY_BITS-1:0] me_M,
    output logic [KEY_BITS-1:0] me_N,
    output logic [KEY_BITS-1:0] me_d,
    output logic                me_start,
    input  logic                me_ready,
    input  logic [KEY_BITS-1:0] me_S,
    output logic                rx_drop
);

    localparam int KEY_BYTES = KEY_BITS / 8;
    localparam int CNT_W     = $clog2(KEY_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_BYTES - 1);

    typedef enum logic [2:0] {
        LOAD_N, LOAD_D, LOAD_M, START, WAIT_BUSY, WAIT_DONE, SEND
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [KEY_BITS-1:0] n_q, n_d;
    logic [KEY_BITS-1:0] d_q, d_d;
    logic [KEY_BITS-1:0] m_q, m_d;
    logic [KEY_BITS-1:0] sr_q, sr_d;
    logic                txv_q, txv_d;

    logic                cnt_last;
    logic [CNT_W-1:0]    cnt_inc;
    logic                loading;
    logic                rekey_req;

    // Big-endian assembly: the newest byte lands in the least significant slot.
    function automatic logic [KEY_BITS-1:0] shift_in(input logic [KEY_BITS-1:0] r,
                                                     input logic [7:0] b);
        return {r[KEY_BITS-9:0], b};
    endfunction

    assign cnt_last = (cnt_q == CNT_LAST);
    assign cnt_inc  = cnt_last ? '0 : cnt_q + CNT_W'(1);
    assign loading  = (state_q == LOAD_N) || (state_q == LOAD_D) || (state_q == LOAD_M);

`ifdef RSA_IO_REKEY_EN
    // Only honoured before the first message byte of a block.
    assign rekey_req = rekey && (state_q == LOAD_M) && (cnt_q == '0);
`else
    assign rekey_req = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        d_d      = d_q;
        m_d      = m_q;
        sr_d     = sr_q;
        txv_d    = txv_q;
        me_start = 1'b0;
        rx_drop  = rx_valid && !loading;

        case (state_q)
            LOAD_N: begin
                if (rx_valid) begin
                    n_d   = shift_in(n_q, rx_data);
                    cnt_d = cnt_inc;
                    if (cnt_last) state_d = LOAD_D;
                end
            end
            LOAD_D: begin
                if (rx_valid) begin
                    d_d   = shift_in(d_q, rx_data);
                    cnt_d = cnt_inc;
                    if (cnt_last) state_d = LOAD_M;
                end
            end
            LOAD_M: begin
                if (rekey_req) begin
                    // A byte arriving with the rekey request is the first N byte.
                    state_d = LOAD_N;
                    cnt_d   = '0;
                    if (rx_valid) begin
                        n_d   = shift_in(n_q, rx_data);
                        cnt_d = CNT_W'(1);
                    end
                end else if (rx_valid) begin
                    m_d   = shift_in(m_q, rx_data);
                    cnt_d = cnt_inc;
                    if (cnt_last) state_d = START;
                end
            end
            START: begin
                me_start = 1'b1;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // The exponentiator drops ready one cycle after start.
                if (!me_ready) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (me_ready) begin
                    sr_d    = me_S;
                    txv_d   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (txv_q && tx_ready) begin
                    sr_d  = {sr_q[KEY_BITS-9:0], 8'h00};
                    cnt_d = cnt_inc;
                    if (cnt_last) begin
                        txv_d   = 1'b0;
                        state_d = LOAD_M;
                    end
                end
            end
            default: state_d = LOAD_N;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD_N;
            cnt_q   <= '0;
            n_q     <= '0;
            d_q     <= '0;
            m_q     <= '0;
            sr_q    <= '0;
            txv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            d_q     <= d_d;
            m_q     <= m_d;
            sr_q    <= sr_d;
            txv_q   <= txv_d;
        end
    end

    assign me_N     = n_q;
    assign me_d     = d_q;
    assign me_M     = m_q;
    assign tx_data  = sr_q[KEY_BITS-1 -: 8];
    assign tx_valid = txv_q;

endmodule

// File: tb/tb_rsa_byte_io.sv
module tb_rsa_byte_io;

    logic         clk;
    logic         reset;
    logic         rekey;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [255:0] me_M, me_N, me_d, me_S;
    logic         me_start, me_ready, rx_drop;

    int total = 0;
    int bad   = 0;

    rsa_byte_io dut (
        .clk      (clk),
        .reset    (reset),
`ifdef RSA_IO_REKEY_EN
        .rekey    (rekey),
`endif
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .me_M     (me_M),
        .me_N     (me_N),
        .me_d     (me_d),
        .me_start (me_start),
        .me_ready (me_ready),
        .me_S     (me_S),
        .rx_drop  (rx_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // M^e mod n, with M reduced byte by byte from its big-endian value.
    function automatic logic [255:0] modexp(input logic [255:0] m, input longint n, input int e);
        longint r;
        longint acc;
        if (n <= 0) return '0;
        r = 0;
        for (int i = 31; i >= 0; i--) r = (r * 256 + longint'(m[8*i +: 8])) % n;
        acc = 1 % n;
        for (int k = 0; k < e; k++) acc = (acc * r) % n;
        return 256'(acc);
    endfunction

    // Behavioural exponentiator: ready drops one cycle after start, busy ~50 cycles.
    initial begin
        logic [255:0] cm, cn, cd;
        me_ready = 1'b1;
        me_S     = '0;
        forever begin
            @(posedge clk);
            #2;
            if (me_start === 1'b1) begin
                cm = me_M; cn = me_N; cd = me_d;
                @(posedge clk);
                #2 me_ready = 1'b0;
                repeat (49) @(posedge clk);
                #2;
                me_S     = modexp(cm, longint'(cn[62:0]), int'(cd[30:0]));
                me_ready = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one 32-byte operand MSB first, one byte per cycle; returns at the
    // falling edge after the last byte was clocked in.
    task automatic send_op(input logic [255:0] v, input logic first_rekey);
        for (int i = 0; i < 32; i++) begin
            rx_data  = v[255-8*i -: 8];
            rx_valid = 1'b1;
            rekey    = first_rekey && (i == 0);
            #1 chk("rx_no_drop", rx_drop, 1'b0);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rekey    = 1'b0;
    endtask

    task automatic wait_result(input logic [255:0] exp_s);
        logic seen_low = 1'b0;
        logic found    = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (me_ready === 1'b0) seen_low = 1'b1;
            else if (seen_low) found = 1'b1;
        end
        chk("ready_rise_seen", found, 1'b1);
        chk("txv_before_lat", tx_valid, 1'b0);
        @(negedge clk);
        chk("txv_after_lat", tx_valid, 1'b1);
        chk("tx_first_byte", tx_data, exp_s[255:248]);
    endtask

    // bp: 0 always ready, 1 ready one cycle in four, 2 random ready.
    task automatic recv_bytes(input logic [255:0] exp_s, input int bp, input int nb);
        logic [7:0] q[$];
        logic [7:0] pd    = 8'h00;
        logic       stall = 1'b0;
        int acc = 0;
        int cyc = 0;
        for (int i = 0; i < 32; i++) q.push_back(exp_s[255-8*i -: 8]);
        while (acc < nb && cyc < 600) begin
            chk("tx_valid_held", tx_valid, 1'b1);
            if (stall) chk("tx_stable", tx_data, pd);
            chk($sformatf("tx_byte%0d", acc), tx_data, q[acc]);
            case (bp)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 4 == 3);
                default: tx_ready = ($urandom_range(0, 3) == 0);
            endcase
            stall = !tx_ready;
            pd    = tx_data;
            if (tx_ready) acc++;
            cyc++;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        chk("tx_count", acc, nb);
        if (nb == 32) chk("tx_valid_end", tx_valid, 1'b0);
    endtask

    task automatic start_block(input logic [255:0] m, input longint n, input int e);
        send_op(m, 1'b0);
        chk("start_pulse", me_start, 1'b1);
        chk("me_N_hold", me_N, 256'(n));
        chk("me_d_hold", me_d, 256'(e));
        chk("me_M_load", me_M, m);
        @(negedge clk);
        chk("start_single", me_start, 1'b0);
    endtask

    task automatic run_block(input logic [255:0] m, input longint n, input int e, input int bp);
        logic [255:0] s;
        s = modexp(m, n, e);
        start_block(m, n, e);
        wait_result(s);
        recv_bytes(s, bp, 32);
    endtask

    initial begin
        logic [255:0] mr;
        reset    = 1'b0;
        rekey    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_txv_low", tx_valid, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_me_M", me_M, 256'd0);
        chk("rst_me_N", me_N, 256'd0);
        chk("rst_me_d", me_d, 256'd0);
        chk("rst_me_start", me_start, 1'b0);
        chk("rst_rx_drop", rx_drop, 1'b0);

        // Key load and first block: 2^7 mod 33 = 29
        send_op(256'd33, 1'b0);
        send_op(256'd7, 1'b0);
        run_block(256'd2, 33, 7, 0);

        // Key retained, backpressure: 5^7 mod 33 = 14
        run_block(256'd5, 33, 7, 1);

        // Random full-width messages
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < 8; w++) mr[32*w +: 32] = $urandom;
            run_block(mr, 33, 7, 2);
        end

        // Bytes arriving while the exponentiator is busy are dropped
        for (int w = 0; w < 8; w++) mr[32*w +: 32] = $urandom;
        start_block(mr, 33, 7);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_data  = 8'($urandom);
            rx_valid = 1'b1;
            #1 chk("drop_pulse", rx_drop, 1'b1);
            @(negedge clk);
            rx_valid = 1'b0;
            #1 chk("drop_clear", rx_drop, 1'b0);
            chk("drop_me_M", me_M, mr);
        end
        wait_result(modexp(mr, 33, 7));
        recv_bytes(modexp(mr, 33, 7), 0, 32);

        // Reset in the middle of SEND
        start_block(256'd2, 33, 7);
        wait_result(256'd29);
        recv_bytes(256'd29, 0, 3);
        chk("pre_rst_txv", tx_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("async_rst_txv", tx_valid, 1'b0);
        chk("async_rst_txd", tx_data, 8'h00);
        chk("async_rst_N", me_N, 256'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_op(256'd33, 1'b0);
        send_op(256'd7, 1'b0);
        run_block(256'd5, 33, 7, 2);

`ifdef RSA_IO_REKEY_EN
        // Rekey before the first message byte: 2^3 mod 55 = 8
        send_op(256'd55, 1'b1);
        send_op(256'd3, 1'b0);
        start_block(256'd2, 55, 3);
        wait_result(256'd8);
        rekey = 1'b1;
        #1 chk("rekey_send_nodrop", rx_drop, 1'b0);
        @(negedge clk);
        rekey = 1'b0;
        chk("rekey_send_txv", tx_valid, 1'b1);
        recv_bytes(256'd8, 0, 32);
        run_block(256'd3, 55, 3, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
